// File: rtl/booth_wallace_mult_pipe.sv
// Pipelined radix-4 Booth multiplier with a Wallace tree of 3:2 compressors.
//
// Four register stages:
//   S1 - operand, mode and tag capture
//   S2 - Booth recoding and partial-product generation
//   S3 - Wallace reduction to a sum/carry pair
//   S4 - carry-propagate add; result and tag register
// A global stall freezes every stage, bubbles included, while the output is
// valid and not accepted.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake (in_ready = ~stall)
//   in_signed              1: operands are two's complement, 0: unsigned
//   in_a, in_b             multiplicand, multiplier (Booth-recoded)
//   in_tag                 side-band tag returned with the result
//   out_valid/out_ready    result handshake
//   out_product, out_tag   a*b modulo 2^(2*WIDTH), and its tag
module booth_wallace_mult_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned P     = 2 * WIDTH;   // product width
  localparam int unsigned NPP   = WIDTH / 2 + 1;
  localparam int unsigned NROWS = NPP + 1;     // partial products plus hot-one row
  localparam int unsigned XW    = WIDTH + 2;   // extended operand width
  localparam int unsigned MW    = WIDTH + 3;   // room for 2*a of an extended operand

  // Row count after 'lvl' levels of 3:2 reduction.
  function automatic int unsigned rows_at(input int unsigned n0, input int unsigned lvl);
    int unsigned n;
    n = n0;
    for (int unsigned k = 0; k < lvl; k++) begin
      if (n > 2) n = (n / 3) * 2 + n % 3;
    end
    return n;
  endfunction

  function automatic int unsigned num_levels(input int unsigned n0);
    int unsigned n;
    int unsigned l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = num_levels(NROWS);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------- S1
  logic             v1_q;
  logic             sgn1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [TAG_W-1:0] tag1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      sgn1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
    end else if (!stall) begin
      v1_q   <= in_valid;
      sgn1_q <= in_signed;
      a1_q   <= in_a;
      b1_q   <= in_b;
      tag1_q <= in_tag;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [XW-1:0]  a_ext, b_ext;
  logic [XW:0]    b_pad;           // b_pad[k] = b_ext[k-1], b_pad[0] = b[-1] = 0
  logic [MW-1:0]  a1m, a2m, sel, mag;
  logic [2:0]     trip;
  logic           neg;
  logic [P-1:0]   pp_ext;
  logic [P-1:0]   pp_d [NPP];
  logic [NPP-1:0] neg_d;

  always_comb begin
    a_ext  = sgn1_q ? {{2{a1_q[WIDTH-1]}}, a1_q} : {2'b00, a1_q};
    b_ext  = sgn1_q ? {{2{b1_q[WIDTH-1]}}, b1_q} : {2'b00, b1_q};
    b_pad  = {b_ext, 1'b0};
    a1m    = {a_ext[XW-1], a_ext};
    a2m    = {a_ext, 1'b0};
    trip   = '0;
    sel    = '0;
    neg    = 1'b0;
    mag    = '0;
    pp_ext = '0;
    neg_d  = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_pad[2*i +: 3];
      sel  = '0;
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: sel = a1m;
        3'b011:         sel = a2m;
        3'b100:         begin sel = a2m; neg = 1'b1; end
        3'b101, 3'b110: begin sel = a1m; neg = 1'b1; end
        default:        sel = '0;
      endcase
      // Ones-complement here; the +1 rides in the hot-one row.
      mag      = neg ? ~sel : sel;
      pp_ext   = {{(P-MW){mag[MW-1]}}, mag};
      pp_d[i]  = pp_ext << (2 * i);
      neg_d[i] = neg;
    end
  end

  logic             v2_q;
  logic [P-1:0]     pp_q [NPP];
  logic [NPP-1:0]   neg_q;
  logic [TAG_W-1:0] tag2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      neg_q  <= '0;
      tag2_q <= '0;
      for (int i = 0; i < NPP; i++) pp_q[i] <= '0;
    end else if (!stall) begin
      v2_q   <= v1_q;
      neg_q  <= neg_d;
      tag2_q <= tag1_q;
      for (int i = 0; i < NPP; i++) pp_q[i] <= pp_d[i];
    end
  end

  // ---------------------------------------------------------------- S3
  logic [P-1:0] hot;

  always_comb begin
    hot = '0;
    for (int i = 0; i < NPP; i++) hot[2*i] = neg_q[i];
  end

  // tree[l] holds the rows entering level l; unused trailing rows are tied to zero.
  logic [P-1:0] tree [LEVELS+1][NROWS];

  for (genvar r = 0; r < NPP; r++) begin : g_row0
    assign tree[0][r] = pp_q[r];
  end
  assign tree[0][NPP] = hot;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned N = rows_at(NROWS, l);
    localparam int unsigned G = N / 3;
    localparam int unsigned M = rows_at(NROWS, l + 1);
    for (genvar g = 0; g < G; g++) begin : g_csa
      assign tree[l+1][2*g]   = tree[l][3*g] ^ tree[l][3*g+1] ^ tree[l][3*g+2];
      // Carry shifted up one column; the carry out of the MSB drops off.
      assign tree[l+1][2*g+1] = ((tree[l][3*g]   & tree[l][3*g+1]) |
                                 (tree[l][3*g]   & tree[l][3*g+2]) |
                                 (tree[l][3*g+1] & tree[l][3*g+2])) << 1;
    end
    for (genvar r = 3 * G; r < N; r++) begin : g_pass
      assign tree[l+1][2*G+r-3*G] = tree[l][r];
    end
    for (genvar r = M; r < NROWS; r++) begin : g_zero
      assign tree[l+1][r] = '0;
    end
  end

  logic             v3_q;
  logic [P-1:0]     sum_q, carry_q;
  logic [TAG_W-1:0] tag3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      tag3_q  <= '0;
    end else if (!stall) begin
      v3_q    <= v2_q;
      sum_q   <= tree[LEVELS][0];
      carry_q <= tree[LEVELS][1];
      tag3_q  <= tag2_q;
    end
  end

  // ---------------------------------------------------------------- S4
  logic             v4_q;
  logic [P-1:0]     prod_q;
  logic [TAG_W-1:0] tag4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4_q   <= 1'b0;
      prod_q <= '0;
      tag4_q <= '0;
    end else if (!stall) begin
      v4_q   <= v3_q;
      prod_q <= sum_q + carry_q;
      tag4_q <= tag3_q;
    end
  end

  assign out_valid   = v4_q;
  assign out_product = prod_q;
  assign out_tag     = tag4_q;

endmodule

// File: tb/tb_booth_wallace_mult_pipe.sv
// Directed and model-checked bench for booth_wallace_mult_pipe at WIDTH 16, 4 and 32.
module tb_booth_wallace_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // WIDTH=16 instance
  logic        v16, s16, ordy16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [3:0]  t16, ot16;
  logic [31:0] p16;

  booth_wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_signed(s16),
    .in_a(a16), .in_b(b16), .in_tag(t16), .out_valid(ov16), .out_ready(ordy16),
    .out_product(p16), .out_tag(ot16)
  );

  // WIDTH=4 instance
  logic       v4, s4, ordy4, ir4, ov4;
  logic [3:0] a4, b4, t4, ot4;
  logic [7:0] p4;

  booth_wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_signed(s4),
    .in_a(a4), .in_b(b4), .in_tag(t4), .out_valid(ov4), .out_ready(ordy4),
    .out_product(p4), .out_tag(ot4)
  );

  // WIDTH=32 instance
  logic        v32, s32, ordy32, ir32, ov32;
  logic [31:0] a32, b32;
  logic [3:0]  t32, ot32;
  logic [63:0] p32;

  booth_wallace_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .in_signed(s32),
    .in_a(a32), .in_b(b32), .in_tag(t32), .out_valid(ov32), .out_ready(ordy32),
    .out_product(p32), .out_tag(ot32)
  );

  // Reference product for operands of width w (upper argument bits must be zero).
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input int w);
    logic [63:0] ax, bx, p;
    ax = {32'b0, a};
    bx = {32'b0, b};
    if (sgn) begin
      ax = ax << (64 - w);
      ax = $signed(ax) >>> (64 - w);
      bx = bx << (64 - w);
      bx = $signed(bx) >>> (64 - w);
    end
    p = ax * bx;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Apply one cycle of inputs to the 16-bit instance, sampling point #2 after the edge.
  task automatic drive16(input logic v, input logic sgn, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] t, input logic ordy);
    @(posedge clk);
    #1;
    v16 = v; s16 = sgn; a16 = a; b16 = b; t16 = t; ordy16 = ordy;
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if (ov16 !== 1'b0 || p16 !== 32'h0 || ot16 !== 4'h0 || ir16 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b p=%h t=%h rdy=%0b, want v=0 p=0 t=0 rdy=1",
               ov16, p16, ot16, ir16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) drive16(1'b1, 1'b0, 16'h0102, 16'h0304, 4'(c + 8), 1'b1);
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
    n_vec++;
    if (ov16 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prefill: got v=%0b, want v=1", ov16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ov16 !== 1'b0 || p16 !== 32'h0 || ot16 !== 4'h0) begin
      n_err++;
      $display("FAIL reset_async: got v=%0b p=%h t=%h, want v=0 p=0 t=0", ov16, p16, ot16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      n_vec++;
      if (ov16 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_stale[%0d]: got v=%0b, want v=0", c, ov16);
      end
    end
    n_vec++;
    if (ir16 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got rdy=%0b, want rdy=1", ir16);
    end
  endtask

  task automatic test_unsigned_max;
    drive16(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 4'd5, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      if (c == 3) begin
        n_vec++;
        if (ov16 !== 1'b0) begin
          n_err++;
          $display("FAIL umax_early: got v=%0b after 3 edges, want v=0", ov16);
        end
      end
    end
    n_vec++;
    if (ov16 !== 1'b1 || p16 !== 32'hFFFE0001 || ot16 !== 4'd5) begin
      n_err++;
      $display("FAIL umax: got v=%0b p=%h t=%h, want v=1 p=fffe0001 t=5", ov16, p16, ot16);
    end
  endtask

  task automatic test_signed;
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic        ts [3];
    logic [31:0] ex [3];
    ta = '{16'h8000, 16'hFFFF, 16'hFFFF};
    tb = '{16'h8000, 16'h0003, 16'h0003};
    ts = '{1'b1, 1'b1, 1'b0};
    ex = '{32'h40000000, 32'hFFFFFFFD, 32'h0002FFFD};
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive16(1'b1, ts[c], ta[c], tb[c], 4'(c + 1), 1'b1);
      else       drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      if (c >= 4) begin
        n_vec++;
        if (ov16 !== 1'b1 || p16 !== ex[c-4] || ot16 !== 4'(c - 3)) begin
          n_err++;
          $display("FAIL signed[%0d]: got v=%0b p=%h t=%h, want v=1 p=%h t=%h",
                   c - 4, ov16, p16, ot16, ex[c-4], 4'(c - 3));
        end
      end
    end
  endtask

  task automatic test_streaming;
    logic [15:0] sa [20];
    logic [15:0] sb [20];
    logic        ss [20];
    logic [3:0]  st [20];
    logic [63:0] ex [20];
    logic [63:0] r;
    for (int i = 0; i < 20; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      ss[i] = 1'($urandom);
      st[i] = 4'(i);
    end
    sa[0] = 16'h0000;
    sb[1] = 16'h0000;
    sa[2] = 16'h8000; sb[2] = 16'h7FFF; ss[2] = 1'b1;
    for (int i = 0; i < 20; i++) ex[i] = ref_mul({16'b0, sa[i]}, {16'b0, sb[i]}, ss[i], 16);
    for (int c = 0; c < 24; c++) begin
      if (c < 20) drive16(1'b1, ss[c], sa[c], sb[c], st[c], 1'b1);
      else        drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      if (c >= 4) begin
        r = ex[c-4];
        n_vec++;
        if (ov16 !== 1'b1 || p16 !== r[31:0] || ot16 !== st[c-4]) begin
          n_err++;
          $display("FAIL stream[%0d]: got v=%0b p=%h t=%h, want v=1 p=%h t=%h",
                   c - 4, ov16, p16, ot16, r[31:0], st[c-4]);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [15:0] ba [5];
    logic [15:0] bb [5];
    logic        bs [5];
    logic [63:0] ex [5];
    logic [63:0] r;
    logic        ordy;
    ba = '{16'h1234, 16'hFFFF, 16'h8001, 16'h00FF, 16'h7FFF};
    bb = '{16'h5678, 16'h0002, 16'h8001, 16'hFF00, 16'h7FFF};
    bs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) ex[i] = ref_mul({16'b0, ba[i]}, {16'b0, bb[i]}, bs[i], 16);
    for (int c = 0; c < 16; c++) begin
      ordy = !(c >= 4 && c <= 9);
      if (c < 4)        drive16(1'b1, bs[c], ba[c], bb[c], 4'(c + 10), 1'b1);
      else if (c <= 10) drive16(1'b1, bs[4], ba[4], bb[4], 4'd14, ordy);
      else              drive16(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      if (c >= 4 && c <= 9) begin
        r = ex[0];
        n_vec++;
        if (ir16 !== 1'b0 || ov16 !== 1'b1 || p16 !== r[31:0] || ot16 !== 4'd10) begin
          n_err++;
          $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b p=%h t=%h, want rdy=0 v=1 p=%h t=a",
                   c, ir16, ov16, p16, ot16, r[31:0]);
        end
      end else if (c >= 10 && c <= 14) begin
        r = ex[c-10];
        n_vec++;
        if (ov16 !== 1'b1 || p16 !== r[31:0] || ot16 !== 4'(c)) begin
          n_err++;
          $display("FAIL bp_drain[%0d]: got v=%0b p=%h t=%h, want v=1 p=%h t=%h",
                   c - 10, ov16, p16, ot16, r[31:0], 4'(c));
        end
        if (c == 10) begin
          n_vec++;
          if (ir16 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got rdy=%0b, want rdy=1", ir16);
          end
        end
      end else if (c == 15) begin
        n_vec++;
        if (ov16 !== 1'b0) begin
          n_err++;
          $display("FAIL bp_no_dup: got v=%0b, want v=0", ov16);
        end
      end
    end
  endtask

  task automatic test_sweep_w4;
    logic [7:0]  eq [$];
    logic [3:0]  tq [$];
    logic [8:0]  cv;
    logic [63:0] r;
    logic [7:0]  e;
    logic [3:0]  et;
    for (int c = 0; c < 516; c++) begin
      @(posedge clk);
      #1;
      ordy4 = 1'b1;
      if (c < 512) begin
        cv = c[8:0];
        a4 = cv[3:0]; b4 = cv[7:4]; s4 = cv[8]; t4 = cv[3:0] ^ cv[7:4]; v4 = 1'b1;
        r = ref_mul({28'b0, a4}, {28'b0, b4}, s4, 4);
        eq.push_back(r[7:0]);
        tq.push_back(t4);
      end else begin
        v4 = 1'b0;
      end
      #1;
      if (c == 0) begin
        n_vec++;
        if (ir4 !== 1'b1) begin
          n_err++;
          $display("FAIL w4_ready: got rdy=%0b, want rdy=1", ir4);
        end
      end
      if (c >= 4) begin
        e  = eq.pop_front();
        et = tq.pop_front();
        n_vec++;
        if (ov4 !== 1'b1 || p4 !== e || ot4 !== et) begin
          n_err++;
          $display("FAIL w4[%0d]: got v=%0b p=%h t=%h, want v=1 p=%h t=%h",
                   c - 4, ov4, p4, ot4, e, et);
        end
      end
    end
    v4 = 1'b0;
  endtask

  task automatic test_sweep_w32;
    logic [63:0] eq [$];
    logic [3:0]  tq [$];
    logic [63:0] e;
    logic [3:0]  et;
    for (int c = 0; c < 10004; c++) begin
      @(posedge clk);
      #1;
      ordy32 = 1'b1;
      if (c < 10000) begin
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom); t32 = 4'($urandom); v32 = 1'b1;
        if (c == 0) begin a32 = 32'h80000000; b32 = 32'h80000000; s32 = 1'b1; end
        if (c == 1) begin a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; s32 = 1'b0; end
        eq.push_back(ref_mul(a32, b32, s32, 32));
        tq.push_back(t32);
      end else begin
        v32 = 1'b0;
      end
      #1;
      if (c == 0) begin
        n_vec++;
        if (ir32 !== 1'b1) begin
          n_err++;
          $display("FAIL w32_ready: got rdy=%0b, want rdy=1", ir32);
        end
      end
      if (c >= 4) begin
        e  = eq.pop_front();
        et = tq.pop_front();
        n_vec++;
        if (ov32 !== 1'b1 || p32 !== e || ot32 !== et) begin
          n_err++;
          $display("FAIL w32[%0d]: got v=%0b p=%h t=%h, want v=1 p=%h t=%h",
                   c - 4, ov32, p32, ot32, e, et);
        end
      end
    end
    v32 = 1'b0;
  endtask

  initial begin
    v16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0; t16 = '0; ordy16 = 1'b1;
    v4  = 1'b0; s4  = 1'b0; a4  = '0; b4  = '0; t4  = '0; ordy4  = 1'b1;
    v32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0; t32 = '0; ordy32 = 1'b1;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_streaming();
    test_back_pressure();
    test_sweep_w4();
    test_sweep_w32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
